// File: rtl/rr_grant_arbiter_8_if.sv
// rr_grant_arbiter_8_if
//   Handshake bundle between the eight requesters and the round-robin
//   arbiter that feeds the 8-to-3 encoder.
//   i_req         : 8-bit level-sensitive request vector (bit i = requester i)
//   i_release     : one-cycle pulse from the current owner ending its grant
//   o_grant       : registered one-hot grant, 8'h00 when idle
//   o_grant_valid : high exactly when o_grant != 0
//   o_busy        : arbiter is in its BUSY state (equals o_grant_valid)
//   o_timeout     : one-cycle pulse when a grant is force-released
//   modport slave  : arbiter side
//   modport master : requester side
interface rr_grant_arbiter_8_if;
  logic [7:0] i_req;
  logic       i_release;
  logic [7:0] o_grant;
  logic       o_grant_valid;
  logic       o_busy;
  logic       o_timeout;

  modport slave (
    input  i_req,
    input  i_release,
    output o_grant,
    output o_grant_valid,
    output o_busy,
    output o_timeout
  );

  modport master (
    output i_req,
    output i_release,
    input  o_grant,
    input  o_grant_valid,
    input  o_busy,
    input  o_timeout
  );
endinterface

// File: rtl/rr_grant_arbiter_8.sv
// rr_grant_arbiter_8
//   Eight-requester round-robin arbiter. Exactly one grant bit is
//   registered at a time, so the downstream encoder only ever sees a legal
//   one-hot vector or all-zero. A grant is held until the owner pulses
//   release, drops its request, or holds it for TIMEOUT_CYCLES cycles.
//   At least one idle cycle separates consecutive grants.
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset
//     arb : rr_grant_arbiter_8_if.slave (req/release in, grant/status out)
//   Parameter:
//     TIMEOUT_CYCLES : maximum hold time in cycles (1..255), 0 disables it
module rr_grant_arbiter_8 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_grant_arbiter_8_if.slave   arb
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam bit         LP_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] LP_TO_LAST = LP_TO_EN ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

  logic [0:0] r_state;
  logic [7:0] r_grant;
  logic [2:0] r_ptr;
  logic [2:0] r_owner;
  logic [7:0] r_hold;
  logic       r_timeout;

  logic       w_found;
  logic [2:0] w_win;
  logic [2:0] w_cand;
  logic       w_end_rel;
  logic       w_end_drop;
  logic       w_end_to;

  // Search ptr+1 .. ptr+8 (mod 8); the first set request wins, so the
  // previous winner is naturally the lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      w_cand = r_ptr + 3'(k);
      if (!w_found && arb.i_req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_end_rel  = arb.i_release;
    w_end_drop = !arb.i_req[r_owner];
    w_end_to   = LP_TO_EN && (r_hold == LP_TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ptr     <= 3'd7;
      r_owner   <= '0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= 8'b0000_0001 << w_win;
            r_owner <= w_win;
            r_hold  <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_end_rel || w_end_drop || w_end_to) begin
            r_grant   <= '0;
            r_state   <= IDLE;
            r_ptr     <= r_owner;
            r_hold    <= '0;
            // A coincident release or dropped request wins over the timeout.
            r_timeout <= w_end_to && !w_end_rel && !w_end_drop;
          end else if (r_hold != 8'hFF) begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign arb.o_grant       = r_grant;
  assign arb.o_grant_valid = (r_grant != 8'h00);
  assign arb.o_busy        = (r_state == BUSY);
  assign arb.o_timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_arbiter_8.sv
// tb_rr_grant_arbiter_8
//   Directed-vector bench with a scoreboard. The driver applies one input
//   vector per clock and, after the edge that consumes it, queues the
//   hand-computed grant/timeout for that edge. A separate monitor pops on
//   every falling edge and compares, and also checks the output invariants.
module tb_rr_grant_arbiter_8;

  logic clk;
  logic rst;

  rr_grant_arbiter_8_if u_if ();

  rr_grant_arbiter_8 #(.TIMEOUT_CYCLES(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .arb (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] grant;
    logic       to;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_valid = 1'b0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one vector, let one edge consume it, then queue its expectation.
  task automatic step(input logic r, input logic [7:0] req, input logic rel,
                      input logic [7:0] eg, input logic eto, input string name);
    exp_t e;
    rst           = r;
    u_if.i_req    = req;
    u_if.i_release = rel;
    @(posedge clk);
    #1;
    e.grant = eg;
    e.to    = eto;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  // Monitor: decoupled from the driver, compares on each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, "_grant"}, u_if.o_grant, e.grant);
      chk({e.name, "_timeout"}, {7'd0, u_if.o_timeout}, {7'd0, e.to});
      chk({e.name, "_valid"}, {7'd0, u_if.o_grant_valid}, {7'd0, (e.grant != 8'h00)});
      chk({e.name, "_busy"}, {7'd0, u_if.o_busy}, {7'd0, (e.grant != 8'h00)});
      chk("inv_onehot", {7'd0, ($countones(u_if.o_grant) <= 1)}, 8'd1);
      chk("inv_valid", {7'd0, u_if.o_grant_valid}, {7'd0, (u_if.o_grant != 8'h00)});
      chk("inv_to_rise", {7'd0, (u_if.o_timeout && u_if.o_grant_valid && !prev_valid)}, 8'd0);
      prev_valid = u_if.o_grant_valid;
    end
  end

  initial begin
    rst            = 1'b1;
    u_if.i_req     = 8'h00;
    u_if.i_release = 1'b0;
    #2;

    // Reset state
    step(1, 8'h00, 0, 8'h00, 0, "reset0");
    step(1, 8'h00, 0, 8'h00, 0, "reset1");

    // Single requester, release ends the grant
    step(0, 8'h01, 0, 8'h01, 0, "t1_grant");
    step(0, 8'h01, 0, 8'h01, 0, "t1_hold1");
    step(0, 8'h01, 0, 8'h01, 0, "t1_hold2");
    step(0, 8'h01, 1, 8'h00, 0, "t1_release");
    step(0, 8'h00, 0, 8'h00, 0, "t1_idle");

    // Full rotation with all requesting, after reset (ptr=7)
    step(1, 8'h00, 0, 8'h00, 0, "t2_reset");
    for (int i = 0; i < 8; i++) begin
      step(0, 8'hFF, 0, 8'h01 << i, 0, "t2_rot_grant");
      step(0, 8'hFF, 1, 8'h00, 0, "t2_rot_gap");
    end
    step(0, 8'hFF, 0, 8'h01, 0, "t2_wrap");
    step(0, 8'hFF, 1, 8'h00, 0, "t2_wrap_rel");

    // Owner 2 releases, then 8'h84 -> bit 7 before bit 2
    step(0, 8'h04, 0, 8'h04, 0, "t3_own2");
    step(0, 8'h04, 1, 8'h00, 0, "t3_rel2");
    step(0, 8'h84, 0, 8'h80, 0, "t3_pick7");
    step(0, 8'h84, 1, 8'h00, 0, "t3_rel7");
    step(0, 8'h00, 0, 8'h00, 0, "t3_idle");

    // Timeout after exactly 16 held cycles, then immediate regrant
    step(0, 8'h10, 0, 8'h10, 0, "t4_grant");
    for (int i = 0; i < 15; i++) step(0, 8'h10, 0, 8'h10, 0, "t4_hold");
    step(0, 8'h10, 0, 8'h00, 1, "t4_timeout");
    step(0, 8'h10, 0, 8'h10, 0, "t4_regrant");
    // Release coincident with the timeout cycle -> normal release
    for (int i = 0; i < 15; i++) step(0, 8'h10, 0, 8'h10, 0, "t4b_hold");
    step(0, 8'h10, 1, 8'h00, 0, "t4b_rel_and_to");
    step(0, 8'h00, 0, 8'h00, 0, "t4b_idle");

    // Owner 5 drops its request; ptr=5 so 8'h21 grants bit 0
    step(0, 8'h20, 0, 8'h20, 0, "t5_grant5");
    step(0, 8'h20, 0, 8'h20, 0, "t5_hold");
    step(0, 8'h00, 0, 8'h00, 0, "t5_drop");
    step(0, 8'h21, 0, 8'h01, 0, "t5_pick0");
    step(0, 8'h21, 1, 8'h00, 0, "t5_rel0");
    step(0, 8'h00, 0, 8'h00, 0, "t5_idle");

    // Reset mid-grant restores ptr=7
    step(0, 8'h08, 0, 8'h08, 0, "t6_grant3");
    step(0, 8'h08, 0, 8'h08, 0, "t6_hold");
    step(1, 8'h08, 0, 8'h00, 0, "t6_rst_busy");
    step(0, 8'h09, 0, 8'h01, 0, "t6_pick0");
    step(0, 8'h09, 0, 8'h01, 0, "t6_hold0");
    step(0, 8'h00, 0, 8'h00, 0, "t6_drop");

    // Release while idle is ignored
    step(0, 8'h00, 1, 8'h00, 0, "t7_idle_rel");
    step(0, 8'h02, 0, 8'h02, 0, "t7_grant1");
    step(0, 8'h00, 0, 8'h00, 0, "t7_drop");

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
    end
  end

endmodule

// File: doc/rr_grant_arbiter_8.md
Name: rr_grant_arbiter_8

Overview:
- Eight-requester round-robin arbiter that sits directly upstream of the 8-to-3 encoder.
- Registers exactly one grant bit, so the encoder always sees a legal one-hot vector or all-zero.
- Holds each grant until the winner releases, drops its request, or exceeds a hold timeout.
- grant_valid qualifies the encoder output, because the encoder maps both 8'h00 and 8'h01 to code 0.

Parameters:
- TIMEOUT_CYCLES, default 16: maximum cycles a grant may be held. Range 1..255. 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  8  request vector; bit i = requester i, level-sensitive
- release  input  1  one-cycle pulse from the current owner ending its grant
- grant  output  8  registered one-hot grant, or 8'h00 when idle; feeds the encoder input
- grant_valid  output  1  high exactly when grant != 0
- busy  output  1  state == BUSY; equals grant_valid
- timeout  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, grant=8'h00, grant_valid=0, busy=0, timeout=0, ptr=3'd7, hold_cnt=0.
- Reset has priority over every other event, including mid-grant.
- Internal state:
  - ptr (3 bits): index of the last winner.
  - hold_cnt (8 bits): cycles the current grant has been held.
  - FSM with states IDLE and BUSY.
- Search order: ptr+1, ptr+2, ..., ptr+8, all mod 8. The first set req bit wins. After reset, req[0] has highest priority.
- IDLE:
  - If req != 0 at edge t: grant = one-hot of the winner, registered from edge t, so latency is 1 cycle. Also grant_valid=1, state=BUSY, hold_cnt=0.
  - If req == 0: stay IDLE with outputs 0.
- BUSY, end conditions evaluated each edge:
  - (a) release=1, or
  - (b) the winner's req bit=0, or
  - (c) TIMEOUT_CYCLES != 0 and hold_cnt == TIMEOUT_CYCLES-1.
- On any end condition:
  - grant=8'h00, grant_valid=0, state=IDLE, ptr=winner index.
  - timeout=1 for one cycle only if (c) is true and neither (a) nor (b) is.
- Otherwise in BUSY: hold_cnt increments, saturating at 255. grant is unchanged and ignores other req changes.
- Mandatory gap: at least one cycle with grant=8'h00 separates consecutive grants, even with continuous requests. Re-arbitration happens in the IDLE cycle using the updated ptr.
- release asserted in IDLE is ignored.
- Fairness:
  - A requester that is released or timed out becomes lowest priority.
  - With all 8 requesting continuously, grants rotate 0,1,2,...,7,0 with no skips.
- Simultaneous events: release together with timeout, or a dropped req together with timeout, counts as a normal release, with timeout=0.
- Invariants, asserted in the bench:
  - $countones(grant) <= 1 at all times.
  - grant_valid == (grant != 0).
  - timeout never asserts while grant_valid is rising.

Test Plan:
- Reset, then req=8'h01 at cycle 0 -> grant=8'h01, grant_valid=1 at cycle 1. release at cycle 3 -> grant=8'h00 at cycle 4. Encoder outputs 3'b000 with grant_valid high in cycles 1-3.
- req=8'hFF held, release pulsed each BUSY cycle -> grant sequence 01,00,02,00,04,00,...,80,00,01. Downstream codes are 0..7 in order.
- After owner 2 releases, req=8'h84 -> next grant=8'h80 (bit 7 follows ptr=2 before wrapping to bit 2).
- TIMEOUT_CYCLES=16, req=8'h10 held, no release -> grant high for exactly 16 cycles, then timeout=1 for one cycle and grant=8'h00. With req still 8'h10, regrant the cycle after.
- Owner 5 drops req[5] mid-grant, with release=0 -> grant=8'h00 next edge, timeout=0, ptr=5. req=8'h21 then grants 8'h01 first.
- rst=1 during BUSY with grant=8'h08 -> next edge grant=8'h00, ptr=7. Then req=8'h09 -> grant=8'h01.
